rsa_modmul: RTL

- Sequential modular multiplier. Computes result = (a * b) mod modulus using MSB-first interleaved shift-add-reduce, one multiplier bit per clock.
- Sits directly beneath the rsa exponentiation stage. The square-and-multiply controller issues one request per square or multiply step and consumes the result before issuing the next.
- No hardware multiplier or divider is used; each iteration needs only an adder and two conditional subtractors.

---
 rtl/rsa_pkg.sv | 12 +
 rtl/rsa_modmul_if.sv | 25 ++
 rtl/rsa_modmul.sv | 99 +++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default width and modular multiplier state encoding.
package rsa_pkg;

  localparam int RSA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } modmul_state_t;

endpackage

// File: rtl/rsa_modmul_if.sv
// Request/response bundle between the exponentiation controller and the modular multiplier.
interface rsa_modmul_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, a, b, modulus,
    input  busy, done, result, err
  );

  modport slave (
    input  start, a, b, modulus,
    output busy, done, result, err
  );
endinterface

// File: rtl/rsa_modmul.sv
// Sequential (a*b) mod N: MSB-first interleaved shift-add-reduce, one multiplier bit per clock.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  rsa_modmul_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  modmul_state_t    state;
  logic [CW-1:0]    cnt;
  logic             bad_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;

  logic             bad;
  logic [WIDTH+1:0] t;

  // T < 3N, so at most two subtractions bring it back below N.
  function automatic logic [WIDTH-1:0] reduce2(input logic [WIDTH+1:0] v,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] nx;
    logic [WIDTH+1:0] x;
    nx = {2'b00, n};
    x  = (v >= nx) ? v - nx : v;
    x  = (x >= nx) ? x - nx : x;
    return x[WIDTH-1:0];
  endfunction

  assign bad = (bus.modulus == '0) || (bus.a >= bus.modulus) || (bus.b >= bus.modulus);
  assign t   = {1'b0, r_q, 1'b0} + (b_q[cnt] ? {2'b00, a_q} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= CW'(WIDTH - 1);
            bad_q  <= bad;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            state  <= bad ? DONE : RUN;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          done_q   <= 1'b1;
          err_q    <= bad_q;
          result_q <= bad_q ? '0 : r_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_q <= bus.a;
      b_q <= bus.b;
      n_q <= bus.modulus;
      r_q <= '0;
    end else if (state == RUN) begin
      r_q <= reduce2(t, n_q);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
